// File: rtl/rx_cmd_framer_if.sv
// Byte-stream input, command output and debug status of the RF command framer.
interface rx_cmd_framer_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [15:0]      cmd_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] pkt_ok_cnt;
  logic [CNT_W-1:0] pkt_err_cnt;
  logic             link_busy;

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output rx_ready, cmd_data, cmd_valid, pkt_ok_cnt, pkt_err_cnt, link_busy
  );

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  rx_ready, cmd_data, cmd_valid, pkt_ok_cnt, pkt_err_cnt, link_busy
  );
endinterface

// File: rtl/rx_cmd_framer.sv
// Frames SYNC/hi/lo/chk packets from the RF byte stream, validates the XOR
// checksum and inter-byte timeout, and forwards good commands to the PWM driver.
module rx_cmd_framer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 5000,
  parameter int          CNT_W       = 8
) (
  input  logic            clk_in,
  input  logic            n_rst,
  rx_cmd_framer_if.slave  bus
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_CHK, S_OUT} state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_hi, r_lo;
  logic [15:0]      r_cmd;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_ok_cnt, r_err_cnt;

  logic w_rx_ready, w_accept, w_busy, w_tmo, w_ok_evt, w_err_evt;

  assign w_rx_ready = (r_state != S_OUT);
  assign w_accept   = bus.rx_valid && w_rx_ready;
  assign w_busy     = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CHK);
  // A byte landing on the expiry cycle takes priority over the timeout.
  assign w_tmo      = w_busy && !w_accept && (r_timer == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_next    = r_state;
    w_ok_evt  = 1'b0;
    w_err_evt = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept && bus.rx_data == SYNC_BYTE) w_next = S_HI;
      S_HI: begin
        if (w_accept)   w_next = S_LO;
        else if (w_tmo) begin w_next = S_IDLE; w_err_evt = 1'b1; end
      end
      S_LO: begin
        if (w_accept)   w_next = S_CHK;
        else if (w_tmo) begin w_next = S_IDLE; w_err_evt = 1'b1; end
      end
      S_CHK: begin
        if (w_accept) begin
          if (bus.rx_data == (r_hi ^ r_lo)) begin
            w_next   = S_OUT;
            w_ok_evt = 1'b1;
          end else begin
            w_next    = S_IDLE;
            w_err_evt = 1'b1;
          end
        end else if (w_tmo) begin
          w_next    = S_IDLE;
          w_err_evt = 1'b1;
        end
      end
      S_OUT:   if (bus.cmd_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cmd     <= '0;
      r_timer   <= '0;
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && r_state == S_HI) r_hi <= bus.rx_data;
      if (w_accept && r_state == S_LO) r_lo <= bus.rx_data;
      if (w_ok_evt) r_cmd <= {r_hi, r_lo};
      // Timer only runs while a packet is in flight and no byte arrives.
      if (w_accept || !w_busy || w_next == S_IDLE) r_timer <= '0;
      else                                         r_timer <= r_timer + 1'b1;
      if (w_ok_evt  && r_ok_cnt  != '1) r_ok_cnt  <= r_ok_cnt  + 1'b1;
      if (w_err_evt && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.rx_ready    = w_rx_ready;
  assign bus.cmd_valid   = (r_state == S_OUT);
  assign bus.cmd_data    = r_cmd;
  assign bus.pkt_ok_cnt  = r_ok_cnt;
  assign bus.pkt_err_cnt = r_err_cnt;
  assign bus.link_busy   = w_busy;

endmodule
